mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_pkg.sv | 36 +++
 rtl/mem_arb_wdog.sv | 36 +++
 rtl/mem_arb.sv | 169 ++++++++++++++++
 tb/tb_mem_arb.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D cache to memory-controller arbiter: bus opcodes,
// FSM states, grant owner and the arbitration rule.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b11
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // On a tie the D-cache wins unless it was the previous winner.
    function automatic owner_t arb_pick(input logic i_req, input logic d_req, input owner_t last);
        owner_t pick;
        if (i_req && d_req) begin
            pick = (last == OWN_D) ? OWN_I : OWN_D;
        end else if (d_req) begin
            pick = OWN_D;
        end else begin
            pick = OWN_I;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_arb_wdog.sv
// WAIT-state watchdog: cleared on WAIT entry, counts WAIT cycles and flags
// expiry on the TIMEOUT_CYCLES-th one. Only built with MEM_ARB_TIMEOUT_EN.
module mem_arb_wdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic active_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (active_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = active_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_arb.sv
// Arbitrates I-cache refills and D-cache refills/writebacks onto a single
// memory-controller port. Optional WAIT watchdog under MEM_ARB_TIMEOUT_EN.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int WORD_SIZE      = 32,
    parameter int CL_SIZE_WIDTH  = 512,
    parameter int ADDR_BITCOUNT  = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_req,
    input  logic [ADDR_BITCOUNT-1:0] i_addr,
    output logic                     i_gnt,
    output logic                     i_rd_valid,
    output logic [CL_SIZE_WIDTH-1:0] i_line,
    input  logic                     d_req,
    input  logic                     d_we,
    input  logic [ADDR_BITCOUNT-1:0] d_addr,
    input  logic [CL_SIZE_WIDTH-1:0] d_wdata,
    output logic                     d_gnt,
    output logic                     d_rd_valid,
    output logic                     d_wr_done,
    output logic [CL_SIZE_WIDTH-1:0] d_line,
    output logic [1:0]               mem_op,
    output logic [ADDR_BITCOUNT-1:0] mem_addr,
    output logic [CL_SIZE_WIDTH-1:0] mem_wdata,
    input  logic                     mem_ready,
    input  logic                     mem_rd_valid,
    input  logic                     mem_tx_done,
    input  logic [CL_SIZE_WIDTH-1:0] mem_rdata,
    output logic                     busy,
    output logic                     err
);

    state_t                   state_q, state_d;
    owner_t                   owner_q, last_q, winner;
    logic                     we_q;
    logic [ADDR_BITCOUNT-1:0] addr_q;
    logic [CL_SIZE_WIDTH-1:0] wdata_q;
    logic [CL_SIZE_WIDTH-1:0] i_line_q, d_line_q;
    logic                     i_gnt_q, d_gnt_q;
    logic                     any_req, grab, rsp_hit, timeout, capture;
    logic [CL_SIZE_WIDTH-1:0] cap_data;
    opcode_t                  op_c;

    assign any_req = i_req || d_req;
    assign winner  = arb_pick(i_req, d_req, last_q);
    assign grab    = (state_q == ST_IDLE) && any_req;
    assign rsp_hit = we_q ? mem_tx_done : mem_rd_valid;

`ifdef MEM_ARB_TIMEOUT_EN
    logic err_q;

    mem_arb_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .start_i  ((state_q == ST_ISSUE) && mem_ready),
        .active_i (state_q == ST_WAIT),
        .expired_o(timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (timeout && !rsp_hit) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    // A real read response wins over a coinciding timeout; a timeout zeroes the line.
    assign capture  = (state_q == ST_WAIT) && ((!we_q && mem_rd_valid) || timeout);
    assign cap_data = (!we_q && mem_rd_valid) ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (any_req) state_d = ST_ISSUE;
            ST_ISSUE: if (mem_ready) state_d = ST_WAIT;
            ST_WAIT:  if (rsp_hit || timeout) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_c       = OP_IDLE;
        i_rd_valid = 1'b0;
        d_rd_valid = 1'b0;
        d_wr_done  = 1'b0;
        case (state_q)
            ST_ISSUE: op_c = we_q ? OP_WRITE : OP_READ;
            ST_DONE: begin
                if (owner_q == OWN_I) begin
                    i_rd_valid = 1'b1;
                end else if (we_q) begin
                    d_wr_done = 1'b1;
                end else begin
                    d_rd_valid = 1'b1;
                end
            end
            default: op_c = OP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWN_I;
            last_q  <= OWN_I;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            i_gnt_q <= 1'b0;
            d_gnt_q <= 1'b0;
        end else begin
            i_gnt_q <= 1'b0;
            d_gnt_q <= 1'b0;
            if (grab) begin
                owner_q <= winner;
                last_q  <= winner;
                we_q    <= (winner == OWN_D) && d_we;
                addr_q  <= (winner == OWN_D) ? d_addr : i_addr;
                wdata_q <= (winner == OWN_D) ? d_wdata : '0;
                i_gnt_q <= (winner == OWN_I);
                d_gnt_q <= (winner == OWN_D);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_line_q <= '0;
            d_line_q <= '0;
        end else if (capture) begin
            if (owner_q == OWN_I) begin
                i_line_q <= cap_data;
            end else begin
                d_line_q <= cap_data;
            end
        end
    end

    assign mem_op    = op_c;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_gnt     = i_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign i_line    = i_line_q;
    assign d_line    = d_line_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios plus randomized
// transactions checked against a transaction-level model of the arbiter.
`timescale 1ns/1ps
module tb_mem_arb;
    localparam int CL = 512;
    localparam int AW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, i_gnt, i_rd_valid;
    logic [AW-1:0] i_addr;
    logic [CL-1:0] i_line;
    logic          d_req, d_we, d_gnt, d_rd_valid, d_wr_done;
    logic [AW-1:0] d_addr;
    logic [CL-1:0] d_wdata, d_line;
    logic [1:0]    mem_op;
    logic [AW-1:0] mem_addr;
    logic [CL-1:0] mem_wdata, mem_rdata;
    logic          mem_ready, mem_rd_valid, mem_tx_done;
    logic          busy, err;

    always #5 clk = ~clk;

    mem_arb #(
        .WORD_SIZE(32), .CL_SIZE_WIDTH(CL), .ADDR_BITCOUNT(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rd_valid(i_rd_valid), .i_line(i_line),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rd_valid(d_rd_valid), .d_wr_done(d_wr_done), .d_line(d_line),
        .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rd_valid(mem_rd_valid), .mem_tx_done(mem_tx_done), .mem_rdata(mem_rdata),
        .busy(busy), .err(err)
    );

    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    // Reference model: which requester went last, what each cache should hold.
    bit            last_d;
    bit            i_pend, d_pend;
    bit            err_m;
    logic [CL-1:0] i_line_m, d_line_m;

    task automatic check_val(input string tag, input logic [CL-1:0] got, input logic [CL-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CL-1:0] rand_line();
        logic [CL-1:0] r;
        for (int k = 0; k < CL / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check_quiet(input string tag);
        check_val({tag, "_igt"}, i_gnt, 0);
        check_val({tag, "_dgt"}, d_gnt, 0);
        check_val({tag, "_ird"}, i_rd_valid, 0);
        check_val({tag, "_drd"}, d_rd_valid, 0);
        check_val({tag, "_dwd"}, d_wr_done, 0);
    endtask

    task automatic check_lines(input string tag);
        check_val({tag, "_iln"}, i_line, i_line_m);
        check_val({tag, "_dln"}, d_line, d_line_m);
        check_val({tag, "_err"}, err, err_m);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_req = 0; d_req = 0; mem_ready = 0; mem_rd_valid = 0; mem_tx_done = 0;
        step();
        last_d = 0; i_pend = 0; d_pend = 0; err_m = 0;
        i_line_m = '0; d_line_m = '0;
        check_quiet("rst");
        check_val("rst_busy", busy, 0);
        check_val("rst_op", mem_op, 2'b00);
        check_val("rst_addr", mem_addr, 0);
        check_val("rst_wdata", mem_wdata, 0);
        check_lines("rst");
        rst = 1'b0;
    endtask

    // Runs one transaction starting in IDLE with i_req/d_req already driven.
    task automatic run_txn(input int rdy_dly, input int rsp_dly, input bit early_drop,
                           input logic [CL-1:0] rd);
        bit            win_d, we;
        logic [1:0]    op;
        logic [AW-1:0] a;
        win_d  = (i_pend && d_pend) ? !last_d : d_pend;
        last_d = win_d;
        we     = win_d && d_we;
        op     = we ? 2'b11 : 2'b01;
        a      = win_d ? d_addr : i_addr;
        txn_no++;
        $display("txn %0d winner=%s we=%0d addr=%h rdy_dly=%0d rsp_dly=%0d",
                 txn_no, win_d ? "D" : "I", we, a, rdy_dly, rsp_dly);
        step();
        check_val("gnt_i", i_gnt, !win_d);
        check_val("gnt_d", d_gnt, win_d);
        check_val("gnt_busy", busy, 1);
        check_val("issue_op", mem_op, op);
        check_val("issue_addr", mem_addr, a);
        if (we) check_val("issue_wdata", mem_wdata, d_wdata);
        if (early_drop) begin
            if (win_d) d_req = 0; else i_req = 0;
        end
        for (int k = 0; k < rdy_dly; k++) begin
            mem_ready = 0;
            step();
            check_val("issue_hold_op", mem_op, op);
            check_val("issue_hold_gnt", i_gnt | d_gnt, 0);
        end
        mem_ready = 1;
        step();
        mem_ready = 1'($urandom);
        check_val("wait_op", mem_op, 2'b00);
        for (int k = 0; k < rsp_dly; k++) begin
            step();
            check_quiet("wait");
            check_val("wait_busy", busy, 1);
        end
        if (we) begin
            mem_tx_done = 1;
        end else begin
            mem_rdata = rd;
            mem_rd_valid = 1;
        end
        step();
        mem_tx_done = 0; mem_rd_valid = 0;
        if (!we) begin
            if (win_d) d_line_m = rd; else i_line_m = rd;
        end
        check_val("done_ird", i_rd_valid, !win_d);
        check_val("done_drd", d_rd_valid, win_d && !we);
        check_val("done_dwd", d_wr_done, we);
        check_lines("done");
        if (win_d) d_pend = 0; else i_pend = 0;
        // Stray responses while not in WAIT must not touch anything.
        mem_rdata = rand_line(); mem_rd_valid = 1; mem_tx_done = 1;
        step();
        mem_rd_valid = 0; mem_tx_done = 0;
        check_val("idle_busy", busy, 0);
        check_quiet("idle");
        check_lines("idle");
    endtask

    task automatic random_round();
        if (!i_pend && ($urandom_range(1, 0) == 1)) begin
            i_pend = 1; i_addr = $urandom;
        end
        if (!d_pend && ($urandom_range(1, 0) == 1)) begin
            d_pend = 1; d_addr = $urandom; d_we = 1'($urandom); d_wdata = rand_line();
        end
        if (!i_pend && !d_pend) begin
            i_pend = 1; i_addr = $urandom;
        end
        i_req = i_pend; d_req = d_pend;
        run_txn($urandom_range(3, 0), $urandom_range(3, 0), ($urandom_range(3, 0) == 0), rand_line());
    endtask

    initial begin
        logic [CL-1:0] pat_a5, pat_5a;
        pat_a5 = {64{8'hA5}};
        pat_5a = {64{8'h5A}};
        i_addr = '0; d_addr = '0; d_we = 0; d_wdata = '0; mem_rdata = '0;
        step();
        do_reset();

        // Single I-cache refill.
        i_pend = 1; i_addr = 32'h0000_1000; i_req = 1;
        run_txn(0, 2, 0, pat_a5);

        // Simultaneous requests after reset: D first, then I.
        do_reset();
        i_pend = 1; i_addr = 32'h0000_2000; i_req = 1;
        d_pend = 1; d_addr = 32'h0000_3000; d_we = 0; d_req = 1;
        run_txn(0, 1, 0, rand_line());
        check_val("tie_i_pending", i_pend, 1);
        i_req = i_pend; d_req = d_pend;
        run_txn(0, 1, 0, rand_line());

        // Writeback with mem_ready held low for 4 cycles.
        d_pend = 1; d_addr = 32'h0000_4000; d_we = 1; d_wdata = pat_5a;
        i_req = i_pend; d_req = 1;
        run_txn(4, 1, 0, '0);

        for (int r = 0; r < 40; r++) random_round();
        i_req = 0; d_req = 0;

        // Reset while in WAIT, then a late read response.
        do_reset();
        i_addr = 32'h0000_5000; i_req = 1;
        step();
        check_val("rw_gnt", i_gnt, 1);
        mem_ready = 1;
        step();
        check_val("rw_wait_op", mem_op, 2'b00);
        rst = 1;
        step();
        rst = 0; i_req = 0; mem_ready = 0;
        check_val("rw_busy", busy, 0);
        check_val("rw_op", mem_op, 2'b00);
        check_quiet("rw");
        check_val("rw_iln", i_line, 0);
        mem_rdata = pat_a5; mem_rd_valid = 1;
        step();
        mem_rd_valid = 0;
        check_quiet("rw_late");
        check_val("rw_late_busy", busy, 0);
        check_val("rw_late_iln", i_line, 0);
        step();
        check_val("rw_late_iln2", i_line, 0);
        last_d = 0; i_pend = 0; d_pend = 0; i_line_m = '0; d_line_m = '0;

`ifdef MEM_ARB_TIMEOUT_EN
        // Load a known line, then let a refill starve in WAIT.
        i_pend = 1; i_addr = 32'h0000_6000; i_req = 1;
        run_txn(0, 0, 0, pat_a5);
        i_pend = 1; i_addr = 32'h0000_7000; i_req = 1;
        step();
        check_val("to_gnt", i_gnt, 1);
        mem_ready = 1;
        step();
        mem_ready = 0;
        for (int k = 1; k < TO; k++) begin
            step();
            check_quiet("to_wait");
            check_val("to_wait_err", err, 0);
        end
        step();
        i_pend = 0; err_m = 1; i_line_m = '0;
        check_val("to_ird", i_rd_valid, 1);
        check_lines("to_done");
        i_req = 0;
        step();
        check_val("to_idle_busy", busy, 0);
        check_val("to_err_sticky", err, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
